game_session_ctrl: RTL and testbench

Game-controller-side session manager that sits on the far end of the multi-user authentication interface. It consumes the authenticator's `LogIn`/`LogOut`/`InternalID` outputs and the player's `Game_Enter` activity. It times each session against a play-time budget and an inactivity limit. When either runs out, it issues the `GCLogOut` request that the authenticator accepts.

---
 rtl/game_session_ctrl_if.sv | 23 ++
 rtl/game_session_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_session_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_session_ctrl_if.sv
// Signal bundle between the authenticator/player side and the game session controller.
// The master side drives login status and player activity; the slave side returns session status.
interface game_session_ctrl_if;
    logic       LogIn;
    logic       LogOut;
    logic [4:0] InternalID;
    logic       Game_Enter;
    logic       GCLogOut;
    logic       SessionActive;
    logic [4:0] ActiveID;
    logic [7:0] TimeLeft;
    logic       Warn;

    modport master (
        output LogIn, LogOut, InternalID, Game_Enter,
        input  GCLogOut, SessionActive, ActiveID, TimeLeft, Warn
    );

    modport slave (
        input  LogIn, LogOut, InternalID, Game_Enter,
        output GCLogOut, SessionActive, ActiveID, TimeLeft, Warn
    );
endinterface

// File: rtl/game_session_ctrl.sv
// Game-side session manager: times each login against a play budget and an inactivity
// limit, and requests a logout from the authenticator when either expires.
module game_session_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int SESSION_SEC   = 120,
    parameter int IDLE_SEC      = 30,
    parameter int WARN_SEC      = 10
) (
    input  logic               clk,
    input  logic               rst,
    game_session_ctrl_if.slave gameBus
);
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0]         SESSION_VAL = 8'(SESSION_SEC);
    localparam logic [7:0]         IDLE_VAL    = 8'(IDLE_SEC);
    localparam logic [7:0]         WARN_VAL    = 8'(WARN_SEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REQ    = 2'd2
    } state_t;

    state_t             stateReg, stateNext;
    logic [PRESC_W-1:0] prescReg, prescNext;
    logic [7:0]         idleCntReg, idleCntNext;
    logic [7:0]         timeLeftReg, timeLeftNext;
    logic [4:0]         activeIdReg, activeIdNext;
    logic               gcLogOutReg, gcLogOutNext;
    logic               sessionActiveReg, sessionActiveNext;
    logic               warnReg, warnNext;
    logic               logInPrevReg;
    logic               gameEnterPrevReg;
    logic               loginArmedReg;

    logic       secTick;
    logic       loginRise;
    logic       activity;
    logic       userLeft;
    logic [7:0] timeDec;
    logic [7:0] idleInc;

    // A login edge only counts once LogIn has been seen low since reset, so a
    // level still high across a reset cannot start a session.
    assign loginRise = gameBus.LogIn & ~logInPrevReg & loginArmedReg;
    assign activity  = gameBus.Game_Enter & ~gameEnterPrevReg;
    assign userLeft  = gameBus.LogOut | ~gameBus.LogIn;
    assign secTick   = (prescReg == PRESC_LAST);
    assign timeDec   = (secTick && timeLeftReg != 8'd0) ? timeLeftReg - 8'd1 : timeLeftReg;
    assign idleInc   = activity ? 8'd0 :
                       ((secTick && idleCntReg < IDLE_VAL) ? idleCntReg + 8'd1 : idleCntReg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg         <= IDLE;
            prescReg         <= '0;
            idleCntReg       <= 8'd0;
            timeLeftReg      <= 8'd0;
            activeIdReg      <= 5'd0;
            gcLogOutReg      <= 1'b0;
            sessionActiveReg <= 1'b0;
            warnReg          <= 1'b0;
            logInPrevReg     <= 1'b0;
            gameEnterPrevReg <= 1'b0;
            loginArmedReg    <= 1'b0;
        end else begin
            stateReg         <= stateNext;
            prescReg         <= prescNext;
            idleCntReg       <= idleCntNext;
            timeLeftReg      <= timeLeftNext;
            activeIdReg      <= activeIdNext;
            gcLogOutReg      <= gcLogOutNext;
            sessionActiveReg <= sessionActiveNext;
            warnReg          <= warnNext;
            logInPrevReg     <= gameBus.LogIn;
            gameEnterPrevReg <= gameBus.Game_Enter;
            loginArmedReg    <= loginArmedReg | ~gameBus.LogIn;
        end
    end

    always_comb begin
        stateNext         = stateReg;
        prescNext         = prescReg;
        idleCntNext       = idleCntReg;
        timeLeftNext      = timeLeftReg;
        activeIdNext      = activeIdReg;
        gcLogOutNext      = gcLogOutReg;
        sessionActiveNext = sessionActiveReg;
        warnNext          = 1'b0;

        case (stateReg)
            IDLE: begin
                gcLogOutNext      = 1'b0;
                sessionActiveNext = 1'b0;
                timeLeftNext      = 8'd0;
                activeIdNext      = 5'd0;
                if (loginRise) begin
                    stateNext         = ACTIVE;
                    sessionActiveNext = 1'b1;
                    activeIdNext      = gameBus.InternalID;
                    timeLeftNext      = SESSION_VAL;
                    prescNext         = '0;
                    idleCntNext       = 8'd0;
                end
            end

            ACTIVE: begin
                prescNext   = secTick ? '0 : prescReg + 1'b1;
                idleCntNext = idleInc;
                if (userLeft) begin
                    stateNext         = IDLE;
                    sessionActiveNext = 1'b0;
                    timeLeftNext      = 8'd0;
                    activeIdNext      = 5'd0;
                end else if (timeDec == 8'd0 || idleInc >= IDLE_VAL) begin
                    // Budget expiry and idle expiry both end in a logout request.
                    stateNext         = REQ;
                    gcLogOutNext      = 1'b1;
                    sessionActiveNext = 1'b0;
                    timeLeftNext      = timeDec;
                end else begin
                    timeLeftNext = timeDec;
                    warnNext     = (timeDec <= WARN_VAL);
                end
            end

            REQ: begin
                gcLogOutNext      = 1'b1;
                sessionActiveNext = 1'b0;
                if (userLeft) begin
                    stateNext    = IDLE;
                    gcLogOutNext = 1'b0;
                    timeLeftNext = 8'd0;
                    activeIdNext = 5'd0;
                end
            end

            default: begin
                stateNext         = IDLE;
                gcLogOutNext      = 1'b0;
                sessionActiveNext = 1'b0;
                timeLeftNext      = 8'd0;
                activeIdNext      = 5'd0;
            end
        endcase
    end

    assign gameBus.GCLogOut      = gcLogOutReg;
    assign gameBus.SessionActive = sessionActiveReg;
    assign gameBus.ActiveID      = activeIdReg;
    assign gameBus.TimeLeft      = timeLeftReg;
    assign gameBus.Warn          = warnReg;
endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all outputs compared every cycle against a session-time model.
module tb_game_session_ctrl;
    localparam int T = 4;
    localparam int S = 5;
    localparam int I = 3;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;

    game_session_ctrl_if gameBus ();

    game_session_ctrl #(
        .TICKS_PER_SEC(T),
        .SESSION_SEC  (S),
        .IDLE_SEC     (I),
        .WARN_SEC     (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .gameBus(gameBus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a session is described by cycles elapsed since its start and the elapsed
    // count at the last activity; seconds and idle seconds follow by integer division.
    bit mActive = 0, mReq = 0, prevLi = 0, prevGe = 0, armed = 0;
    int el = 0, actEl = 0, mTl = 0, mId = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mActive = 0; mReq = 0; prevLi = 0; prevGe = 0; armed = 0;
            el = 0; actEl = 0; mTl = 0; mId = 0;
        end else if (clk) begin
            bit li, lo, ge, rise, act;
            int secs, tl, idle;
            li = gameBus.LogIn; lo = gameBus.LogOut; ge = gameBus.Game_Enter;
            rise = li && !prevLi && armed;
            act  = ge && !prevGe;
            if (mActive) begin
                el++;
                if (act) actEl = el;
                secs = el / T;
                tl   = (S > secs) ? S - secs : 0;
                idle = secs - actEl / T;
                if (lo || !li) begin
                    mActive = 0; mTl = 0; mId = 0;
                end else if (tl == 0 || idle >= I) begin
                    mActive = 0; mReq = 1; mTl = tl;
                end else begin
                    mTl = tl;
                end
            end else if (mReq) begin
                if (lo || !li) begin
                    mReq = 0; mTl = 0; mId = 0;
                end
            end else if (rise) begin
                mActive = 1; el = 0; actEl = 0; mId = int'(gameBus.InternalID); mTl = S;
            end
            armed  = armed || !li;
            prevLi = li;
            prevGe = ge;
            #1;
            chk("GCLogOut", int'(gameBus.GCLogOut), int'(mReq));
            chk("SessionActive", int'(gameBus.SessionActive), int'(mActive));
            chk("ActiveID", int'(gameBus.ActiveID), mId);
            chk("TimeLeft", int'(gameBus.TimeLeft), mTl);
            chk("Warn", int'(gameBus.Warn), int'(mActive && mTl <= W && mTl != 0));
        end
    end

    task automatic chkAllZero(input string tag);
        chk({tag, "_gc"}, int'(gameBus.GCLogOut), 0);
        chk({tag, "_sa"}, int'(gameBus.SessionActive), 0);
        chk({tag, "_id"}, int'(gameBus.ActiveID), 0);
        chk({tag, "_tl"}, int'(gameBus.TimeLeft), 0);
        chk({tag, "_warn"}, int'(gameBus.Warn), 0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        gameBus.LogIn = 0; gameBus.LogOut = 0; gameBus.InternalID = 0; gameBus.Game_Enter = 0;
        cyc(3);
        chkAllZero("reset");
        rst = 1;
        cyc(1);

        // 1: full budget with periodic activity
        gameBus.InternalID = 5'd9; gameBus.LogIn = 1;
        cyc(1);
        chk("s1_id", int'(gameBus.ActiveID), 9);
        chk("s1_tl", int'(gameBus.TimeLeft), 5);
        chk("s1_sa", int'(gameBus.SessionActive), 1);
        for (int k = 1; k <= 19; k++) begin
            if (k % 8 == 0) gameBus.Game_Enter = ~gameBus.Game_Enter;
            cyc(1);
        end
        chk("s1_gc_early", int'(gameBus.GCLogOut), 0);
        chk("s1_tl_1", int'(gameBus.TimeLeft), 1);
        chk("s1_warn_1", int'(gameBus.Warn), 1);
        cyc(1);
        chk("s1_gc", int'(gameBus.GCLogOut), 1);
        chk("s1_tl_0", int'(gameBus.TimeLeft), 0);
        gameBus.LogIn = 0; gameBus.Game_Enter = 0;
        cyc(1);
        chkAllZero("s1_end");
        $display("scenario 1: budget expiry session done");

        // 2: idle expiry, then LogOut handshake
        gameBus.InternalID = 5'd17; gameBus.LogIn = 1;
        cyc(12);
        chk("s2_gc_early", int'(gameBus.GCLogOut), 0);
        cyc(1);
        chk("s2_gc", int'(gameBus.GCLogOut), 1);
        chk("s2_tl", int'(gameBus.TimeLeft), 2);
        chk("s2_id", int'(gameBus.ActiveID), 17);
        gameBus.LogOut = 1;
        cyc(1);
        gameBus.LogOut = 0;
        chkAllZero("s2_idle");
        cyc(5);
        chk("s2_no_restart", int'(gameBus.SessionActive), 0);
        gameBus.LogIn = 0;
        cyc(1);
        $display("scenario 2: idle expiry and LogOut handshake done");

        // 3: activity on the third second tick rescues the session
        gameBus.InternalID = 5'd3; gameBus.LogIn = 1;
        cyc(12);
        gameBus.Game_Enter = 1;
        cyc(1);
        chk("s3_no_req", int'(gameBus.GCLogOut), 0);
        chk("s3_tl", int'(gameBus.TimeLeft), 2);
        gameBus.Game_Enter = 0;
        cyc(7);
        chk("s3_gc_early", int'(gameBus.GCLogOut), 0);
        cyc(1);
        chk("s3_gc", int'(gameBus.GCLogOut), 1);
        chk("s3_tl_0", int'(gameBus.TimeLeft), 0);
        gameBus.LogIn = 0;
        cyc(1);
        $display("scenario 3: coincident activity and tick done");

        // 4: LogOut in the cycle the budget expires
        gameBus.InternalID = 5'd21; gameBus.LogIn = 1;
        cyc(1);
        for (int k = 1; k <= 19; k++) begin
            cyc(1);
            gameBus.Game_Enter = ~gameBus.Game_Enter;
        end
        gameBus.LogOut = 1;
        cyc(1);
        gameBus.LogOut = 0;
        chk("s4_gc", int'(gameBus.GCLogOut), 0);
        chk("s4_sa", int'(gameBus.SessionActive), 0);
        cyc(3);
        chk("s4_gc_later", int'(gameBus.GCLogOut), 0);
        gameBus.LogIn = 0; gameBus.Game_Enter = 0;
        cyc(1);
        $display("scenario 4: LogOut wins over budget expiry done");

        // 5: REQ holds indefinitely; only a fresh login edge restarts
        gameBus.InternalID = 5'd30; gameBus.LogIn = 1;
        cyc(13);
        chk("s5_gc", int'(gameBus.GCLogOut), 1);
        chk("s5_tl", int'(gameBus.TimeLeft), 2);
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            chk("s5_gc_hold", int'(gameBus.GCLogOut), 1);
        end
        gameBus.LogIn = 0;
        cyc(1);
        chkAllZero("s5_idle");
        gameBus.LogIn = 1;
        cyc(1);
        chk("s5_restart", int'(gameBus.SessionActive), 1);
        gameBus.LogIn = 0;
        cyc(1);
        $display("scenario 5: REQ hold and fresh login done");

        // 6: asynchronous reset mid-session
        gameBus.InternalID = 5'd12; gameBus.LogIn = 1;
        cyc(1);
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            gameBus.Game_Enter = ~gameBus.Game_Enter;
        end
        chk("s6_tl", int'(gameBus.TimeLeft), 3);
        #2 rst = 0;
        #1 chkAllZero("s6_async");
        cyc(1);
        rst = 1;
        cyc(6);
        chk("s6_no_start", int'(gameBus.SessionActive), 0);
        gameBus.LogIn = 0;
        cyc(1);
        gameBus.LogIn = 1;
        cyc(1);
        chk("s6_start", int'(gameBus.SessionActive), 1);
        chk("s6_tl_start", int'(gameBus.TimeLeft), 5);
        gameBus.LogIn = 0; gameBus.Game_Enter = 0;
        cyc(1);
        $display("scenario 6: async reset and re-arm done");

        // Randomized traffic, checked every cycle by the model
        for (int k = 0; k < 4000; k++) begin
            cyc(1);
            if ($urandom_range(0, 15) == 0) gameBus.LogIn = ~gameBus.LogIn;
            gameBus.LogOut     = ($urandom_range(0, 39) == 0);
            gameBus.InternalID = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) gameBus.Game_Enter = ~gameBus.Game_Enter;
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 0;
                #1 chkAllZero("rand_async");
                cyc(1);
                rst = 1;
            end
        end
        $display("random phase: 4000 cycles done");

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
